// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared defaults and occupancy-width helper for the UART TX FIFO
package uart_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_DEPTH      = 16;
   localparam int DEFAULT_AF_THR     = 12;

   // Occupancy needs one extra bit so that a completely full FIFO is representable.
   function automatic int occ_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - register-array storage, one sync write port, one async read port
module uart_fifo_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Contents are deliberately left unreset; only the control state is reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - first-word-fall-through transmit FIFO with status and sticky overflow
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int AF_THR     = DEFAULT_AF_THR
) (
   input  logic                           clk_i,
   input  logic                           rstn_i,
   input  logic                           clr_i,
   input  logic [DATA_WIDTH-1:0]          wr_data_i,
   input  logic                           wr_valid_i,
   output logic                           wr_ready_o,
   output logic [DATA_WIDTH-1:0]          rd_data_o,
   output logic                           rd_valid_o,
   input  logic                           rd_ready_i,
   output logic [occ_width(DEPTH)-1:0]    count_o,
   output logic                           empty_o,
   output logic                           full_o,
   output logic                           almost_full_o,
   output logic                           overflow_o,
   input  logic                           ovf_clr_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = occ_width(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_THR);

   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          ovf_q;
   logic          push;
   logic          pop;

   assign empty_o       = (count_q == '0);
   assign full_o        = (count_q == FULL_CNT);
   assign almost_full_o = (count_q >= AF_CNT);
   assign wr_ready_o    = !full_o;
   assign rd_valid_o    = !empty_o;
   assign count_o       = count_q;
   assign overflow_o    = ovf_q;

   assign push = wr_valid_i && wr_ready_o;
   assign pop  = rd_valid_o && rd_ready_i;

   uart_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (push && !clr_i),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_data_i),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data_o)
   );

   // Pointers are exactly AW bits wide so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         // A fresh drop takes priority over a software clear in the same cycle.
         if (wr_valid_i && full_o) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr_i) begin
            ovf_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed table-driven bench for uart_tx_fifo
module tb_uart_tx_fifo;

   logic       clk_i = 1'b0;
   logic       rstn_i;
   logic       clr_i;
   logic [7:0] wr_data_i;
   logic       wr_valid_i;
   logic       wr_ready_o;
   logic [7:0] rd_data_o;
   logic       rd_valid_o;
   logic       rd_ready_i;
   logic [4:0] count_o;
   logic       empty_o;
   logic       full_o;
   logic       almost_full_o;
   logic       overflow_o;
   logic       ovf_clr_i;

   always #5 clk_i = ~clk_i;

   uart_tx_fifo dut (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .clr_i         (clr_i),
      .wr_data_i     (wr_data_i),
      .wr_valid_i    (wr_valid_i),
      .wr_ready_o    (wr_ready_o),
      .rd_data_o     (rd_data_o),
      .rd_valid_o    (rd_valid_o),
      .rd_ready_i    (rd_ready_i),
      .count_o       (count_o),
      .empty_o       (empty_o),
      .full_o        (full_o),
      .almost_full_o (almost_full_o),
      .overflow_o    (overflow_o),
      .ovf_clr_i     (ovf_clr_i)
   );

   typedef struct {
      string      name;
      logic       clr;
      logic       wv;
      logic [7:0] wd;
      logic       rr;
      logic       oc;
      logic [4:0] cnt;
      logic       emp;
      logic       ful;
      logic       af;
      logic       ovf;
      logic [7:0] rdd;
      logic       chkd;
   } vec_t;

   vec_t       tbl[$];
   logic [7:0] model[$];
   int         vectors     = 0;
   int         miscompares = 0;

   function automatic vec_t mk(input string name, input logic clr, input logic wv,
                               input logic [7:0] wd, input logic rr, input logic oc,
                               input logic [4:0] cnt, input logic emp, input logic ful,
                               input logic af, input logic ovf, input logic [7:0] rdd,
                               input logic chkd);
      vec_t v;
      v.name = name; v.clr = clr; v.wv = wv; v.wd = wd; v.rr = rr; v.oc = oc;
      v.cnt = cnt; v.emp = emp; v.ful = ful; v.af = af; v.ovf = ovf;
      v.rdd = rdd; v.chkd = chkd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // {count, empty, full, almost_full, overflow, rd_valid, wr_ready}
   function automatic logic [31:0] status_act();
      return {21'd0, count_o, empty_o, full_o, almost_full_o, overflow_o, rd_valid_o, wr_ready_o};
   endfunction

   function automatic logic [31:0] status_exp(input logic [4:0] cnt, input logic emp,
                                              input logic ful, input logic af, input logic ovf);
      return {21'd0, cnt, emp, ful, af, ovf, !emp, !ful};
   endfunction

   task automatic drive(input logic clr, input logic wv, input logic [7:0] wd,
                        input logic rr, input logic oc);
      clr_i = clr; wr_valid_i = wv; wr_data_i = wd; rd_ready_i = rr; ovf_clr_i = oc;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rstn_i = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Table: basic order, fill to full, overflow and clear priority.
      tbl.push_back(mk("push41", 0, 1, 8'h41, 0, 0, 5'd1, 0, 0, 0, 0, 8'h41, 1));
      tbl.push_back(mk("push42", 0, 1, 8'h42, 0, 0, 5'd2, 0, 0, 0, 0, 8'h41, 1));
      tbl.push_back(mk("push43", 0, 1, 8'h43, 0, 0, 5'd3, 0, 0, 0, 0, 8'h41, 1));
      tbl.push_back(mk("pop41",  0, 0, 8'h00, 1, 0, 5'd2, 0, 0, 0, 0, 8'h42, 1));
      tbl.push_back(mk("pop42",  0, 0, 8'h00, 1, 0, 5'd1, 0, 0, 0, 0, 8'h43, 1));
      tbl.push_back(mk("pop43",  0, 0, 8'h00, 1, 0, 5'd0, 1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk("pop_empty", 0, 0, 8'h00, 1, 0, 5'd0, 1, 0, 0, 0, 8'h00, 0));
      for (int i = 0; i < 16; i++) begin
         tbl.push_back(mk($sformatf("fill%0d", i + 1), 0, 1, 8'(8'h10 + i), 0, 0,
                          5'(i + 1), 0, (i == 15), (i >= 11), 0, 8'h10, 1));
      end
      tbl.push_back(mk("overflow",   0, 1, 8'h99, 0, 0, 5'd16, 0, 1, 1, 1, 8'h10, 1));
      tbl.push_back(mk("ovf_clr",    0, 0, 8'h00, 0, 1, 5'd16, 0, 1, 1, 0, 8'h10, 1));
      tbl.push_back(mk("ovf_set_wins", 0, 1, 8'h9a, 0, 1, 5'd16, 0, 1, 1, 1, 8'h10, 1));
      tbl.push_back(mk("ovf_clr2",   0, 0, 8'h00, 0, 1, 5'd16, 0, 1, 1, 0, 8'h10, 1));
      tbl.push_back(mk("pop_full",   0, 0, 8'h00, 1, 0, 5'd15, 0, 0, 1, 0, 8'h11, 1));
      tbl.push_back(mk("af_edge",    0, 0, 8'h00, 1, 0, 5'd14, 0, 0, 1, 0, 8'h12, 1));
      tbl.push_back(mk("clr_full",   1, 1, 8'hee, 1, 0, 5'd0, 1, 0, 0, 0, 8'h00, 0));

      #1;
      check("reset_state", status_act(), status_exp(5'd0, 1, 0, 0, 0));
      @(negedge clk_i);
      rstn_i = 1'b1;
      step();
      check("post_release", status_act(), status_exp(5'd0, 1, 0, 0, 0));

      foreach (tbl[k]) begin
         drive(tbl[k].clr, tbl[k].wv, tbl[k].wd, tbl[k].rr, tbl[k].oc);
         step();
         check(tbl[k].name, status_act(),
               status_exp(tbl[k].cnt, tbl[k].emp, tbl[k].ful, tbl[k].af, tbl[k].ovf));
         if (tbl[k].chkd) check({tbl[k].name, "_data"}, 32'(rd_data_o), 32'(tbl[k].rdd));
      end

      // Clear at count 7 with a push and a pop pending in the same cycle.
      for (int i = 0; i < 7; i++) begin
         drive(0, 1, 8'(8'h60 + i), 0, 0);
         step();
      end
      check("clr_pre_count", 32'(count_o), 32'd7);
      drive(1, 1, 8'hee, 1, 0);
      step();
      check("clr_status", status_act(), status_exp(5'd0, 1, 0, 0, 0));
      drive(0, 1, 8'ha5, 0, 0);
      step();
      check("clr_next_count", 32'(count_o), 32'd1);
      check("clr_next_data", 32'(rd_data_o), 32'h0a5);
      drive(0, 0, 8'h00, 1, 0);
      step();
      check("clr_drain", status_act(), status_exp(5'd0, 1, 0, 0, 0));

      // Steady state at count 5: 40 simultaneous push/pop cycles wrap the pointers twice.
      model.delete();
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 8'(8'h80 + i), 0, 0);
         model.push_back(8'(8'h80 + i));
         step();
      end
      for (int i = 0; i < 40; i++) begin
         logic [7:0] nd;
         nd = 8'($urandom_range(0, 255));
         check($sformatf("stream_head%0d", i), 32'(rd_data_o), 32'(model[0]));
         drive(0, 1, nd, 1, 0);
         void'(model.pop_front());
         model.push_back(nd);
         step();
         check($sformatf("stream_count%0d", i), 32'(count_o), 32'd5);
      end
      for (int i = 0; i < 5; i++) begin
         check($sformatf("stream_drain%0d", i), 32'(rd_data_o), 32'(model[0]));
         void'(model.pop_front());
         drive(0, 0, 8'h00, 1, 0);
         step();
      end
      check("stream_empty", status_act(), status_exp(5'd0, 1, 0, 0, 0));

      // Asynchronous reset mid-stream at count 9.
      for (int i = 0; i < 9; i++) begin
         drive(0, 1, 8'(8'hc0 + i), 0, 0);
         step();
      end
      drive(0, 0, 8'h00, 0, 0);
      check("rst_pre_count", 32'(count_o), 32'd9);
      #1;
      rstn_i = 1'b0;
      #1;
      check("rst_async", status_act(), status_exp(5'd0, 1, 0, 0, 0));
      @(negedge clk_i);
      rstn_i = 1'b1;
      step();
      check("rst_release", status_act(), status_exp(5'd0, 1, 0, 0, 0));
      drive(0, 1, 8'h55, 0, 0);
      step();
      check("rst_first_push", status_act(), status_exp(5'd1, 0, 0, 0, 0));
      check("rst_first_data", 32'(rd_data_o), 32'h055);
      drive(0, 0, 8'h00, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, character width.
REQ-002 SHALL have parameter DEPTH, default 16, entries; power of two, >= 2.
REQ-003 SHALL have parameter AF_THR, default 12, almost-full threshold in entries.
REQ-004 SHALL have port clk_i  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clr_i  input  1  synchronous flush.
REQ-007 SHALL have port wr_data_i  input  DATA_WIDTH  character from the bus side.
REQ-008 SHALL have port wr_valid_i  input  1  write request.
REQ-009 SHALL have port wr_ready_o  output  1  space available.
REQ-010 SHALL have port rd_data_o  output  DATA_WIDTH  head entry, driven to the transmitter data input.
REQ-011 SHALL have port rd_valid_o  output  1  head valid, driven to the transmitter valid input.
REQ-012 SHALL have port rd_ready_i  input  1  transmitter ready to accept.
REQ-013 SHALL have port count_o  output  $clog2(DEPTH)+1  occupancy.
REQ-014 SHALL have port empty_o, full_o, almost_full_o  output  1 each  status flags.
REQ-015 SHALL have port overflow_o  output  1  sticky dropped-write flag.
REQ-016 SHALL have port ovf_clr_i  input  1  clears overflow_o.

Function
REQ-017 Push SHALL occur when wr_valid_i && wr_ready_o; wr_ready_o = !full_o.
REQ-018 Pop SHALL occur when rd_valid_o && rd_ready_i; rd_valid_o = !empty_o.
REQ-019 Read SHALL be first-word-fall-through: rd_data_o = entry at read pointer, combinational from storage; rd_data_o is don't-care while empty.
REQ-020 Latency SHALL be one cycle: a push into an empty FIFO at edge N gives rd_valid_o=1 after edge N.
REQ-021 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH without a stall cycle.
REQ-022 count_o SHALL update as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on idle.
REQ-023 A simultaneous push and pop SHALL be legal at any non-empty, non-full occupancy.
REQ-024 There SHALL be no pop when empty and no push when full; no bypass path exists.
REQ-025 empty_o SHALL equal (count_o==0); full_o SHALL equal (count_o==DEPTH); almost_full_o SHALL equal (count_o>=AF_THR).
REQ-026 wr_valid_i=1 while full_o=1 SHALL drop the data, leave pointers unchanged, and set overflow_o at the next edge.
REQ-027 overflow_o SHALL stay 1 until ovf_clr_i=1 or clr_i=1; on the same cycle as a new overflow, set wins over ovf_clr_i.
REQ-028 clr_i SHALL zero the pointers, count and overflow at the next edge and SHALL override any push or pop on that cycle.
REQ-029 Order SHALL be strictly FIFO; data SHALL never be reordered or duplicated.
REQ-030 Storage contents SHALL NOT be reset; only control state is reset.

Reset
REQ-031 While rstn_i=0 the block SHALL force pointers=0, count_o=0, empty_o=1, full_o=0, almost_full_o=0, overflow_o=0, rd_valid_o=0 and wr_ready_o=1, asynchronously.
REQ-032 Reset asserted mid-transfer SHALL discard all entries; the first push after release is read first.
REQ-033 Deassertion of rstn_i SHALL take effect on the next clk_i edge without glitching rd_valid_o.

Structure
REQ-034 Shared package uart_pkg SHALL hold the default DATA_WIDTH, the default DEPTH and the occupancy-width function/constant.
REQ-035 Storage SHALL be one sub-module, uart_fifo_mem: a register array with one synchronous write port and one asynchronous read port, no reset.
REQ-036 Control (pointers, count, flags, overflow) SHALL reside in uart_tx_fifo.

Verification
REQ-037 Reset, then push 0x41,0x42,0x43 with rd_ready_i=0 -> count_o=3, rd_data_o=0x41; then rd_ready_i=1 for 3 cycles -> 0x41,0x42,0x43 in order, empty_o=1.
REQ-038 Push 16 entries (DEPTH=16) -> full_o=1, wr_ready_o=0, almost_full_o=1 from count 12; a 17th wr_valid_i -> overflow_o=1, count_o stays 16, head unchanged.
REQ-039 At count 5, push and pop simultaneously for 40 cycles -> count_o stays 5, pointers wrap twice, output sequence matches input sequence.
REQ-040 At count 7, assert clr_i together with wr_valid_i and rd_ready_i -> next cycle count_o=0, empty_o=1, overflow_o=0, and neither the pushed value nor a popped value is observed.
REQ-041 Assert rstn_i=0 mid-stream at count 9 -> immediately count_o=0, rd_valid_o=0; after release push 0x55 -> rd_data_o=0x55 one cycle later.
REQ-042 Overflow occurring on the same cycle as ovf_clr_i -> overflow_o=1; ovf_clr_i alone next cycle -> overflow_o=0.
